int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 21 ++
 rtl/int_prio_enc.sv | 23 ++
 rtl/int_ctrl.sv | 98 +++++++++
 tb/tb_int_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and sizes for the interrupt controller.
// Holds the source count, cause width, FSM state type and a one-hot helper.
package int_ctrl_pkg;

    localparam int NUM_SRC = 8;
    localparam int CAUSE_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [CAUSE_W-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports the lowest-numbered set bit of req_i.
// Purely combinational; valid_o is low when no bit is set.
module int_prio_enc
    import int_ctrl_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    output logic               valid_o,
    output logic [CAUSE_W-1:0] idx_o
);

    // Scan downwards so the last hit, the lowest index, wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending/mask registers, priority pick, IDLE/REQ/SERVICE handshake.
// Define INT_CTRL_EDGE_DETECT_EN to capture rising edges of Int instead of levels.
module int_ctrl
    import int_ctrl_pkg::*;
(
    input  logic               CLK,
    input  logic               Reset,
    input  logic [NUM_SRC-1:0] Int,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               ack,
    input  logic               done,
    output logic               irq,
    output logic [CAUSE_W-1:0] cause,
    output logic [NUM_SRC-1:0] pend,
    output logic [NUM_SRC-1:0] mask
);

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   pend_q, pend_d;
    logic [NUM_SRC-1:0]   mask_q, mask_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [NUM_SRC-1:0]   cap;
    logic [NUM_SRC-1:0]   clr;
    logic                 win_vld;
    logic [CAUSE_W-1:0]   win_idx;

`ifdef INT_CTRL_EDGE_DETECT_EN
    logic [NUM_SRC-1:0]   int_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            int_q <= '0;
        end else begin
            int_q <= Int;
        end
    end

    assign cap = Int & ~int_q;
`else
    assign cap = Int;
`endif

    int_prio_enc u_prio_enc (
        .req_i   (pend_q & mask_q),
        .valid_o (win_vld),
        .idx_o   (win_idx)
    );

    // cause is only loaded on IDLE->REQ, so it stays frozen through REQ and SERVICE.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = REQ;
                    cause_d = win_idx;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = SERVICE;
                    clr     = onehot(cause_q);
                end
            end
            SERVICE: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~clr) | cap;
        mask_d = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            cause_q <= cause_d;
        end
    end

    assign irq   = (state_q == REQ);
    assign cause = cause_q;
    assign pend  = pend_q;
    assign mask  = mask_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl; expected request causes are queued as stimulus is driven.
// Expectations for the held-line scenario follow INT_CTRL_EDGE_DETECT_EN.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [7:0] Int;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic       done;
    logic       irq;
    logic [2:0] cause;
    logic [7:0] pend;
    logic [7:0] mask;

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];

    int_ctrl dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Int        (Int),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .done       (done),
        .irq        (irq),
        .cause      (cause),
        .pend       (pend),
        .mask       (mask)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // Waits (bounded) for irq, then pops the expected cause from the scoreboard.
    task automatic wait_req(input string nm);
        int n;
        int exp_c;
        n = 0;
        while (irq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_irq: irq=%b required 1 within 20 cycles", nm, irq);
        end else if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: request with cause=%0d but none expected", nm, cause);
        end else begin
            exp_c = sb.pop_front();
            n_tests++;
            if (cause !== 3'(exp_c)) begin
                n_fail++;
                $display("FAIL %s_cause: cause=%0d required %0d", nm, cause, exp_c);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Int = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; done = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        n_tests++;
        if ({irq, cause, pend, mask} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset: irq=%b cause=%0d pend=%h mask=%h required all 0", irq, cause, pend, mask);
        end
        n_tests++;
        if (dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d required IDLE", dut.state_q);
        end
    endtask

    task automatic test_basic();
        write_mask(8'hFF);
        n_tests++;
        if (mask !== 8'hFF) begin n_fail++; $display("FAIL mask_wr: mask=%h required ff", mask); end
        Int = 8'h05;
        sb.push_back(0);
        tick();
        Int = 8'h00;
        n_tests++;
        if (pend !== 8'h05 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1: pend=%h irq=%b required pend=05 irq=0", pend, irq);
        end
        tick();
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL lat2: irq=%b required 1", irq); end
        wait_req("basic0");
        // New source while in REQ must not disturb cause.
        Int = 8'h02;
        tick();
        Int = 8'h00;
        n_tests++;
        if (cause !== 3'd0 || pend !== 8'h07 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL frozen: cause=%0d pend=%h irq=%b required cause=0 pend=07 irq=1", cause, pend, irq);
        end
        pulse_ack();
        n_tests++;
        if (pend !== 8'h06 || irq !== 1'b0 || dut.state_q !== SERVICE) begin
            n_fail++;
            $display("FAIL ack0: pend=%h irq=%b state=%0d required pend=06 irq=0 SERVICE", pend, irq, dut.state_q);
        end
        sb.push_back(1);
        pulse_done();
        n_tests++;
        if (dut.state_q !== IDLE || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL done0: state=%0d irq=%b required IDLE irq=0", dut.state_q, irq);
        end
        wait_req("basic1");
        pulse_ack();
        n_tests++;
        if (pend !== 8'h04) begin n_fail++; $display("FAIL ack1: pend=%h required 04", pend); end
        sb.push_back(2);
        pulse_done();
        wait_req("basic2");
        pulse_ack();
        pulse_done();
        n_tests++;
        if (pend !== 8'h00 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: pend=%h irq=%b required 00 0", pend, irq);
        end
    endtask

    task automatic test_mask();
        write_mask(8'h10);
        Int = 8'h11;
        sb.push_back(4);
        tick();
        Int = 8'h00;
        wait_req("mask4");
        n_tests++;
        if (pend !== 8'h11) begin n_fail++; $display("FAIL masked_pend: pend=%h required 11", pend); end
        pulse_ack();
        n_tests++;
        if (pend !== 8'h01) begin n_fail++; $display("FAIL mask_ack: pend=%h required 01", pend); end
        write_mask(8'h01);
        n_tests++;
        if (mask !== 8'h01 || irq !== 1'b0 || dut.state_q !== SERVICE) begin
            n_fail++;
            $display("FAIL mask_svc: mask=%h irq=%b state=%0d required 01 0 SERVICE", mask, irq, dut.state_q);
        end
        sb.push_back(0);
        pulse_done();
        wait_req("mask0");
        pulse_ack();
        pulse_done();
    endtask

    task automatic test_ignored();
        pulse_ack();
        n_tests++;
        if (dut.state_q !== IDLE || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_idle: state=%0d irq=%b required IDLE 0", dut.state_q, irq);
        end
        Int = 8'h01;
        sb.push_back(0);
        tick();
        Int = 8'h00;
        wait_req("ign");
        pulse_done();
        n_tests++;
        if (irq !== 1'b1 || dut.state_q !== REQ) begin
            n_fail++;
            $display("FAIL done_req: irq=%b state=%0d required 1 REQ", irq, dut.state_q);
        end
        ack = 1'b1; done = 1'b1;
        tick();
        ack = 1'b0; done = 1'b0;
        n_tests++;
        if (dut.state_q !== SERVICE || pend !== 8'h00) begin
            n_fail++;
            $display("FAIL ack_done: state=%0d pend=%h required SERVICE 00", dut.state_q, pend);
        end
        pulse_ack();
        n_tests++;
        if (dut.state_q !== SERVICE) begin
            n_fail++;
            $display("FAIL ack_svc: state=%0d required SERVICE", dut.state_q);
        end
        pulse_done();
    endtask

    task automatic test_reset_mid();
        write_mask(8'hFF);
        Int = 8'h80;
        sb.push_back(7);
        tick();
        Int = 8'h00;
        wait_req("rst7");
        Reset = 1'b1; ack = 1'b1; done = 1'b1; mask_we = 1'b1; mask_wdata = 8'hFF; Int = 8'hFF;
        tick();
        Reset = 1'b0; ack = 1'b0; done = 1'b0; mask_we = 1'b0; Int = 8'h00;
        n_tests++;
        if ({irq, cause, pend, mask} !== 20'h0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid: irq=%b cause=%0d pend=%h mask=%h state=%0d required all 0 IDLE",
                     irq, cause, pend, mask, dut.state_q);
        end
    endtask

    task automatic test_held_line();
        logic saw;
        write_mask(8'hFF);
        Int = 8'h08;
        sb.push_back(3);
        tick();
        wait_req("held");
        pulse_ack();
`ifdef INT_CTRL_EDGE_DETECT_EN
        n_tests++;
        if (pend !== 8'h00) begin n_fail++; $display("FAIL held_pend: pend=%h required 00", pend); end
        pulse_done();
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (irq === 1'b1) saw = 1'b1;
        end
        Int = 8'h00;
        n_tests++;
        if (saw !== 1'b0) begin n_fail++; $display("FAIL held_norearm: irq seen=%b required 0", saw); end
`else
        n_tests++;
        if (pend !== 8'h08) begin n_fail++; $display("FAIL held_pend: pend=%h required 08", pend); end
        sb.push_back(3);
        pulse_done();
        wait_req("held2");
        repeat (4) tick();
        Int = 8'h00;
        pulse_ack();
        n_tests++;
        if (pend !== 8'h00) begin n_fail++; $display("FAIL held_clr: pend=%h required 00", pend); end
        pulse_done();
`endif
        saw = irq;
        n_tests++;
        if (saw !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: irq=%b queued=%0d required 0 0", saw, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_ignored();
        test_reset_mid();
        test_held_line();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
